// File: rtl/sram_req_rsp_adapter.sv
// sram_req_rsp_adapter: valid/ready request front-end for a fixed-latency SRAM with a credit-limited response FIFO
// Ports: clk_i/rst_ni clock and async active-low reset; req_* request channel (valid/ready, we, addr with
// out-of-range MSB, wdata, be); rsp_* response channel (valid/ready, rdata, we echo, err); sram_* macro
// interface (req/we/addr/wdata/be out, rdata in after Latency cycles); busy_o any request in flight or buffered.
module sram_req_rsp_adapter #(
  parameter int NumWords  = 1024,
  parameter int DataWidth = 32,
  parameter int ByteWidth = 8,
  parameter int Latency   = 1,
  parameter int RspDepth  = 2,
  parameter int AddrWidth = (NumWords > 1) ? $clog2(NumWords) : 1,
  parameter int BeWidth   = (DataWidth + ByteWidth - 1) / ByteWidth
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic                 req_we_i,
  input  logic [AddrWidth:0]   req_addr_i,
  input  logic [DataWidth-1:0] req_wdata_i,
  input  logic [BeWidth-1:0]   req_be_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [DataWidth-1:0] rsp_rdata_o,
  output logic                 rsp_we_o,
  output logic                 rsp_err_o,
  output logic                 sram_req_o,
  output logic                 sram_we_o,
  output logic [AddrWidth-1:0] sram_addr_o,
  output logic [DataWidth-1:0] sram_wdata_o,
  output logic [BeWidth-1:0]   sram_be_o,
  input  logic [DataWidth-1:0] sram_rdata_i,
  output logic                 busy_o
);
  localparam int CW = $clog2(RspDepth + 1);
  localparam int PW = (RspDepth > 1) ? $clog2(RspDepth) : 1;
  logic [CW-1:0]        inflight_q, count_q;
  logic [PW-1:0]        rd_ptr_q, wr_ptr_q;
  logic [Latency-1:0]   pv_q, pwe_q, perr_q;
  logic [DataWidth-1:0] mem_rdata [RspDepth];
  logic                 mem_we    [RspDepth];
  logic                 mem_err   [RspDepth];
  logic                 hs, err, push, pop, full;
  logic [CW:0]          used;
  logic [DataWidth-1:0] push_data;
  assign err          = req_addr_i >= (AddrWidth + 1)'(NumWords);
  assign rsp_valid_o  = count_q != '0;
  assign pop          = rsp_valid_o && rsp_ready_i;
  assign used         = {1'b0, inflight_q} + {1'b0, count_q};
  // a same-cycle pop returns its credit immediately so full-rate streaming is possible
  assign req_ready_o  = (used < (CW + 1)'(RspDepth)) || pop;
  assign hs           = req_valid_i && req_ready_o;
  assign sram_req_o   = hs && !err;
  assign sram_we_o    = req_we_i;
  assign sram_addr_o  = req_addr_i[AddrWidth-1:0];
  assign sram_wdata_o = req_wdata_i;
  assign sram_be_o    = req_be_i;
  assign push         = pv_q[Latency-1];
  assign push_data    = (pwe_q[Latency-1] || perr_q[Latency-1]) ? '0 : sram_rdata_i;
  assign full         = count_q == CW'(RspDepth);
  assign busy_o       = (|pv_q) || rsp_valid_o;
  assign rsp_rdata_o  = rsp_valid_o ? mem_rdata[rd_ptr_q] : '0;
  assign rsp_we_o     = rsp_valid_o && mem_we[rd_ptr_q];
  assign rsp_err_o    = rsp_valid_o && mem_err[rd_ptr_q];
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pv_q       <= '0;
      pwe_q      <= '0;
      perr_q     <= '0;
      inflight_q <= '0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      pv_q[0]    <= hs;
      pwe_q[0]   <= req_we_i;
      perr_q[0]  <= err;
      for (int i = 1; i < Latency; i++) begin
        pv_q[i]   <= pv_q[i-1];
        pwe_q[i]  <= pwe_q[i-1];
        perr_q[i] <= perr_q[i-1];
      end
      inflight_q <= inflight_q + CW'(hs) - CW'(push);
      count_q    <= count_q + CW'(push) - CW'(pop);
      if (push) wr_ptr_q <= (wr_ptr_q == PW'(RspDepth - 1)) ? '0 : wr_ptr_q + 1'b1;
      if (pop) rd_ptr_q <= (rd_ptr_q == PW'(RspDepth - 1)) ? '0 : rd_ptr_q + 1'b1;
    end
  end
  // storage needs no reset: outputs are gated by rsp_valid_o
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_rdata[wr_ptr_q] <= push_data;
      mem_we[wr_ptr_q]    <= pwe_q[Latency-1];
      mem_err[wr_ptr_q]   <= perr_q[Latency-1];
    end
  end
  assert property (@(posedge clk_i) disable iff (!rst_ni) !(push && full && !pop))
    else $error("response FIFO overflow");
endmodule

// File: tb/tb_sram_req_rsp_adapter.sv
// tb_sram_req_rsp_adapter: directed self-checking bench for sram_req_rsp_adapter
module tb_sram_req_rsp_adapter;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int checks = 0;
  int errors = 0;
  logic        rst_n, req_valid, req_ready, req_we, rsp_valid, rsp_ready, rsp_we, rsp_err;
  logic        sram_req, sram_we, busy;
  logic [10:0] req_addr;
  logic [9:0]  sram_addr;
  logic [31:0] req_wdata, rsp_rdata, sram_wdata, sram_rdata;
  logic [3:0]  req_be, sram_be;
  logic        rst_n2, req_valid2, req_ready2, rsp_valid2, rsp_ready2, rsp_we2, rsp_err2;
  logic        sram_req2, sram_we2, busy2;
  logic [10:0] req_addr2;
  logic [9:0]  sram_addr2;
  logic [31:0] rsp_rdata2, sram_wdata2, sram_rdata2, d1;
  logic [3:0]  sram_be2;
  sram_req_rsp_adapter #(.NumWords(1000), .DataWidth(32), .ByteWidth(8), .Latency(1), .RspDepth(2)) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_be_i(req_be), .rsp_valid_o(rsp_valid),
    .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata), .rsp_we_o(rsp_we), .rsp_err_o(rsp_err),
    .sram_req_o(sram_req), .sram_we_o(sram_we), .sram_addr_o(sram_addr), .sram_wdata_o(sram_wdata),
    .sram_be_o(sram_be), .sram_rdata_i(sram_rdata), .busy_o(busy));
  sram_req_rsp_adapter #(.NumWords(1000), .DataWidth(32), .ByteWidth(8), .Latency(2), .RspDepth(3)) u_dut2 (
    .clk_i(clk), .rst_ni(rst_n2), .req_valid_i(req_valid2), .req_ready_o(req_ready2), .req_we_i(1'b0),
    .req_addr_i(req_addr2), .req_wdata_i(32'h0), .req_be_i(4'hF), .rsp_valid_o(rsp_valid2),
    .rsp_ready_i(rsp_ready2), .rsp_rdata_o(rsp_rdata2), .rsp_we_o(rsp_we2), .rsp_err_o(rsp_err2),
    .sram_req_o(sram_req2), .sram_we_o(sram_we2), .sram_addr_o(sram_addr2), .sram_wdata_o(sram_wdata2),
    .sram_be_o(sram_be2), .sram_rdata_i(sram_rdata2), .busy_o(busy2));
  logic [31:0] mem [1024];
  always @(posedge clk) begin
    if (sram_req) begin
      if (sram_we) begin
        for (int b = 0; b < 4; b++) if (sram_be[b]) mem[sram_addr][b*8 +: 8] <= sram_wdata[b*8 +: 8];
      end else sram_rdata <= mem[sram_addr];
    end
  end
  always @(posedge clk) begin
    d1          <= 32'hC0DE_0000 | 32'(sram_addr2);
    sram_rdata2 <= d1;
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset;
    rst_n = 1'b0; rst_n2 = 1'b0;
    req_valid = 0; req_we = 0; req_addr = '0; req_wdata = '0; req_be = '0; rsp_ready = 1;
    req_valid2 = 0; req_addr2 = '0; rsp_ready2 = 0;
    repeat (3) tick();
    rst_n = 1'b1; rst_n2 = 1'b1;
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h0) begin
      errors++; $display("FAIL reset_rsp valid=%b rdata=%h exp valid=0 rdata=0", rsp_valid, rsp_rdata);
    end
    checks++;
    if (rsp_we !== 1'b0 || rsp_err !== 1'b0) begin
      errors++; $display("FAIL reset_flags we=%b err=%b exp 0 0", rsp_we, rsp_err);
    end
    checks++;
    if (sram_req !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_idle sram_req=%b busy=%b exp 0 0", sram_req, busy);
    end
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready got=%b exp=1", req_ready);
    end
    tick();
  endtask
  task automatic test_read_after_write;
    req_valid = 1; req_we = 1; req_addr = 11'd5; req_wdata = 32'hDEADBEEF; req_be = 4'hF;
    #1;
    checks++;
    if (sram_req !== 1'b1 || sram_we !== 1'b1 || sram_addr !== 10'd5 || sram_wdata !== 32'hDEADBEEF) begin
      errors++; $display("FAIL raw_issue req=%b we=%b addr=%0d wdata=%h exp 1 1 5 deadbeef", sram_req, sram_we, sram_addr, sram_wdata);
    end
    tick();
    req_we = 0;
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL raw_cycle1 rsp_valid=%b busy=%b exp 0 1", rsp_valid, busy);
    end
    tick();
    req_valid = 0;
    #1;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_we !== 1'b1 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
      errors++; $display("FAIL raw_wrsp valid=%b we=%b rdata=%h err=%b exp 1 1 0 0", rsp_valid, rsp_we, rsp_rdata, rsp_err);
    end
    tick();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_we !== 1'b0 || rsp_rdata !== 32'hDEADBEEF) begin
      errors++; $display("FAIL raw_rrsp valid=%b we=%b rdata=%h exp 1 0 deadbeef", rsp_valid, rsp_we, rsp_rdata);
    end
    tick();
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL raw_drain rsp_valid=%b busy=%b exp 0 0", rsp_valid, busy);
    end
  endtask
  task automatic test_back_to_back;
    rsp_ready = 1; req_we = 1; req_be = 4'hF;
    for (int i = 0; i < 8; i++) begin
      req_valid = 1; req_addr = 11'(16 + i); req_wdata = 32'hB000_0000 + 32'(i);
      tick();
    end
    req_valid = 0; req_we = 0;
    repeat (3) tick();
    for (int c = 0; c < 10; c++) begin
      req_valid = (c < 8); req_addr = 11'(16 + c);
      #1;
      if (c < 8) begin
        checks++;
        if (req_ready !== 1'b1) begin
          errors++; $display("FAIL b2b_ready cycle=%0d got=%b exp=1", c, req_ready);
        end
      end
      if (c >= 2) begin
        checks++;
        if (rsp_valid !== 1'b1 || rsp_we !== 1'b0 || rsp_rdata !== 32'hB000_0000 + 32'(c - 2)) begin
          errors++; $display("FAIL b2b_rsp%0d valid=%b we=%b rdata=%h exp 1 0 %h", c - 2, rsp_valid, rsp_we, rsp_rdata, 32'hB000_0000 + 32'(c - 2));
        end
      end
      tick();
    end
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++; $display("FAIL b2b_extra rsp_valid=%b exp=0", rsp_valid);
    end
  endtask
  task automatic test_backpressure;
    int acc = 0;
    rsp_ready = 0; req_we = 0; req_valid = 1;
    for (int c = 0; c < 5; c++) begin
      req_addr = 11'(16 + acc);
      #1;
      if (req_ready) acc++;
      tick();
    end
    checks++;
    if (acc != 2 || req_ready !== 1'b0) begin
      errors++; $display("FAIL bp_accept accepted=%0d ready=%b exp 2 0", acc, req_ready);
    end
    checks++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hB000_0000) begin
      errors++; $display("FAIL bp_head valid=%b rdata=%h exp 1 b0000000", rsp_valid, rsp_rdata);
    end
    tick();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hB000_0000 || req_ready !== 1'b0) begin
      errors++; $display("FAIL bp_stable valid=%b rdata=%h ready=%b exp 1 b0000000 0", rsp_valid, rsp_rdata, req_ready);
    end
    req_valid = 0; rsp_ready = 1;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL bp_pop_ready got=%b exp=1", req_ready);
    end
    tick();
    rsp_ready = 0;
    #1;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hB000_0001 || req_ready !== 1'b1) begin
      errors++; $display("FAIL bp_second valid=%b rdata=%h ready=%b exp 1 b0000001 1", rsp_valid, rsp_rdata, req_ready);
    end
    rsp_ready = 1;
    tick();
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++; $display("FAIL bp_drain rsp_valid=%b exp=0", rsp_valid);
    end
  endtask
  task automatic test_out_of_range;
    logic        wv [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    logic [10:0] av [4] = '{11'd999, 11'd999, 11'd1000, 11'd20};
    logic        sv [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    logic        ev [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [31:0] dv [4] = '{32'h0, 32'h0000_0999, 32'h0, 32'hB000_0004};
    rsp_ready = 1; req_be = 4'hF; req_wdata = 32'h0000_0999;
    for (int c = 0; c < 6; c++) begin
      req_valid = (c < 4);
      if (c < 4) begin req_we = wv[c]; req_addr = av[c]; end
      #1;
      if (c < 4) begin
        checks++;
        if (sram_req !== sv[c] || req_ready !== 1'b1) begin
          errors++; $display("FAIL oor_issue%0d sram_req=%b ready=%b exp %b 1", c, sram_req, req_ready, sv[c]);
        end
      end
      if (c >= 2) begin
        checks++;
        if (rsp_valid !== 1'b1 || rsp_we !== wv[c-2] || rsp_err !== ev[c-2] || rsp_rdata !== dv[c-2]) begin
          errors++; $display("FAIL oor_rsp%0d valid=%b we=%b err=%b rdata=%h exp 1 %b %b %h", c - 2, rsp_valid, rsp_we, rsp_err, rsp_rdata, wv[c-2], ev[c-2], dv[c-2]);
        end
      end
      tick();
    end
  endtask
  task automatic test_partial_write;
    rsp_ready = 1; req_valid = 1; req_we = 1; req_addr = 11'd9;
    req_wdata = 32'hAABBCCDD; req_be = 4'hF;
    tick();
    req_wdata = 32'h11223344; req_be = 4'h5;
    tick();
    req_we = 0;
    tick();
    req_valid = 0;
    tick();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_we !== 1'b0 || rsp_rdata !== 32'hAA22CC44) begin
      errors++; $display("FAIL partial_read valid=%b we=%b rdata=%h exp 1 0 aa22cc44", rsp_valid, rsp_we, rsp_rdata);
    end
    tick();
  endtask
  task automatic test_reset_mid;
    int stale = 0;
    rsp_ready2 = 0;
    for (int c = 0; c < 3; c++) begin
      req_valid2 = 1; req_addr2 = 11'(c);
      #1;
      checks++;
      if (req_ready2 !== 1'b1) begin
        errors++; $display("FAIL rst_issue%0d ready=%b exp=1", c, req_ready2);
      end
      tick();
    end
    req_valid2 = 0;
    #1;
    checks++;
    if (rsp_valid2 !== 1'b1 || busy2 !== 1'b1 || req_ready2 !== 1'b0) begin
      errors++; $display("FAIL rst_pre valid=%b busy=%b ready=%b exp 1 1 0", rsp_valid2, busy2, req_ready2);
    end
    #1 rst_n2 = 1'b0;
    #1;
    checks++;
    if (rsp_valid2 !== 1'b0 || busy2 !== 1'b0 || req_ready2 !== 1'b1) begin
      errors++; $display("FAIL rst_async valid=%b busy=%b ready=%b exp 0 0 1", rsp_valid2, busy2, req_ready2);
    end
    tick();
    rst_n2 = 1'b1; rsp_ready2 = 1;
    for (int c = 0; c < 8; c++) begin
      #1;
      if (rsp_valid2 || busy2) stale++;
      tick();
    end
    checks++;
    if (stale != 0) begin
      errors++; $display("FAIL rst_stale cycles=%0d exp=0", stale);
    end
    req_valid2 = 1; req_addr2 = 11'd7;
    tick();
    req_valid2 = 0;
    tick();
    tick();
    checks++;
    if (rsp_valid2 !== 1'b1 || rsp_rdata2 !== 32'hC0DE_0007 || rsp_err2 !== 1'b0) begin
      errors++; $display("FAIL rst_after valid=%b rdata=%h err=%b exp 1 c0de0007 0", rsp_valid2, rsp_rdata2, rsp_err2);
    end
  endtask
  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
  initial begin
    test_reset();
    test_read_after_write();
    test_back_to_back();
    test_backpressure();
    test_out_of_range();
    test_partial_write();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sram_req_rsp_adapter.md
Name: sram_req_rsp_adapter

Overview:
- Single-port front-end placed directly upstream of the SRAM macro wrapper.
- Converts a valid/ready request channel into the SRAM's fixed-latency req/we/addr/wdata/be interface.
- Captures read data after Latency cycles into a response FIFO with valid/ready.
- Credit-limited issue so responses never overflow under output backpressure; out-of-range addresses are flagged instead of being issued.

Parameters:
NumWords, 1024, number of SRAM words; any value >= 1
DataWidth, 32, data width in bits
ByteWidth, 8, bits per byte-enable lane
Latency, 1, SRAM read latency in cycles; must be >= 1 and match the macro
RspDepth, 2, response FIFO depth and maximum outstanding responses; must be >= 1
AddrWidth, derived, (NumWords > 1) ? $clog2(NumWords) : 1; do not override
BeWidth, derived, ceil(DataWidth/ByteWidth); do not override

Ports:
clk_i  input  1  clock; single clock domain
rst_ni  input  1  asynchronous reset, active low
req_valid_i  input  1  request valid
req_ready_o  output  1  request accepted when valid && ready
req_we_i  input  1  1 = write, 0 = read
req_addr_i  input  AddrWidth+1  word address; MSB allows out-of-range detection
req_wdata_i  input  DataWidth  write data
req_be_i  input  BeWidth  byte enables
rsp_valid_o  output  1  response valid
rsp_ready_i  input  1  response consumed when valid && ready
rsp_rdata_o  output  DataWidth  read data; 0 for writes and errors
rsp_we_o  output  1  echo of the request's we
rsp_err_o  output  1  1 = address >= NumWords
sram_req_o  output  1  to SRAM req
sram_we_o  output  1  to SRAM we
sram_addr_o  output  AddrWidth  to SRAM addr (low bits of req_addr_i)
sram_wdata_o  output  DataWidth  to SRAM wdata
sram_be_o  output  BeWidth  to SRAM be
sram_rdata_i  input  DataWidth  from SRAM rdata; valid Latency cycles after sram_req_o
busy_o  output  1  any request in flight or FIFO non-empty

Behaviour:
- Reset (async assert, sync release): pipeline and FIFO cleared.
  - Reset values: rsp_valid_o=0, rsp_rdata_o=0, rsp_we_o=0, rsp_err_o=0, sram_req_o=0, busy_o=0.
  - req_ready_o=1 when RspDepth>=1.
  - Reset mid-operation discards all in-flight and buffered responses; no response for them ever appears.
- Credits:
  - used = inflight count + FIFO occupancy.
  - req_ready_o = (used < RspDepth) || (rsp_valid_o && rsp_ready_i).
  - A same-cycle pop frees a credit combinationally. rsp_ready_i->req_ready_o is the only combinational input-to-output path besides the request passthrough.
  - req_ready_o does not depend on req_valid_i.
- Issue (cycle t, handshake fires):
  - err = (req_addr_i >= NumWords).
  - sram_req_o = handshake && !err, combinational.
  - sram_we_o/addr/wdata/be are driven combinationally from the request inputs.
  - sram_we_o/wdata/be are don't-care when sram_req_o=0.
  - Every accepted request (read, write, or err) produces exactly one response, in acceptance order.
- Pipeline: a Latency-deep shift register of {valid, we, err}.
  - At cycle t+Latency the entry pushes into the FIFO.
  - Pushed data is sram_rdata_i if (!we && !err), else 0.
- FIFO:
  - RspDepth entries, registered, not fall-through.
  - rsp_valid_o asserts from cycle t+Latency+1. Request-to-response latency is Latency+1.
  - Output fields are stable while rsp_valid_o && !rsp_ready_i.
- Simultaneous push and pop are legal at any occupancy, including full.
- The credit scheme guarantees no overflow; an assertion flags a push to a full FIFO without a pop.
- Throughput: one request/cycle sustained with rsp_ready_i=1 iff RspDepth >= Latency+1. Otherwise issue stalls accordingly.
- busy_o = |pipeline valid bits || FIFO non-empty, combinational from state.
- Counter widths: $clog2(RspDepth+1). Counters wrap never (bounded by credits). FIFO pointers wrap modulo RspDepth; RspDepth need not be a power of 2.

Test Plan:
- Read after write:
  - Stimulus (Latency=1, RspDepth=2): write addr 5, data 0xDEADBEEF, be 0xF, then read addr 5.
  - Required: write response we=1, rdata=0 at cycle 2; read response rdata=0xDEADBEEF one cycle later.
- Back-to-back reads:
  - Stimulus: 8 reads, rsp_ready_i=1, Latency=1, RspDepth=2.
  - Required: req_ready_o stays 1; 8 responses on 8 consecutive cycles, in order.
- Backpressure:
  - Stimulus: rsp_ready_i=0, issue reads.
  - Required: exactly 2 accepted, then req_ready_o=0. FIFO holds 2 with stable outputs.
  - Then rsp_ready_i=1 for one cycle: one pop, req_ready_o=1 in that same cycle.
- Out-of-range read:
  - Stimulus: NumWords=1000, read addr 1000.
  - Required: sram_req_o=0; response err=1, rdata=0, in order with its neighbours.
- Partial write:
  - Stimulus: write 0x11223344 be=0x5, then read.
  - Required: only bytes 0 and 2 updated.
- Reset mid-operation:
  - Stimulus: Latency=2, RspDepth=3; 3 reads issued, assert rst_ni low for 1 cycle.
  - Required: rsp_valid_o=0 and busy_o=0 immediately; no stale responses after release; req_ready_o=1.
